// File: rtl/ddr_arrow_sequencer_pkg.sv
// Shared encodings for the arrow sequencer: game-state values driven by the
// top-level game controller, the sequencer FSM states and a lane popcount.
package ddr_arrow_sequencer_pkg;

    // Game-state encodings; any other value pauses the sequencer
    localparam logic [1:0] STATE_RESET = 2'b00;
    localparam logic [1:0] STATE_GAME  = 2'b01;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_DONE  = 2'd3
    } seqState_t;

    // Number of lanes set in a 4-lane row
    function automatic logic [2:0] popcount4(input logic [3:0] bits);
        popcount4 = 3'(bits[0]) + 3'(bits[1]) + 3'(bits[2]) + 3'(bits[3]);
    endfunction

endpackage

// File: rtl/ddr_pattern_rom.sv
// Song pattern ROM: pattern index -> 4-lane arrow row {R,U,D,L}.
// Purely combinational; contents are fixed for this song.
module ddr_pattern_rom #(
    parameter int SONG_LEN = 64,
    parameter int IDX_W    = $clog2(SONG_LEN)
) (
    input  logic [IDX_W-1:0] idx,
    output logic [3:0]       row
);

    // Case lookup of the song row at idx; unused indices read as empty rows
    always_comb begin
        row = 4'b0000;
        case (int'(idx))
            0:  row = 4'h1;  1:  row = 4'h2;  2:  row = 4'h4;  3:  row = 4'h8;
            4:  row = 4'h3;  5:  row = 4'h0;  6:  row = 4'h5;  7:  row = 4'hA;
            8:  row = 4'h0;  9:  row = 4'hC;  10: row = 4'h1;  11: row = 4'h0;
            12: row = 4'h9;  13: row = 4'h6;  14: row = 4'h0;  15: row = 4'hF;
            16: row = 4'h2;  17: row = 4'h0;  18: row = 4'h4;  19: row = 4'h0;
            20: row = 4'h8;  21: row = 4'h1;  22: row = 4'h0;  23: row = 4'h3;
            24: row = 4'h5;  25: row = 4'h0;  26: row = 4'h6;  27: row = 4'h0;
            28: row = 4'hA;  29: row = 4'h0;  30: row = 4'hC;  31: row = 4'h0;
            32: row = 4'h1;  33: row = 4'h1;  34: row = 4'h2;  35: row = 4'h2;
            36: row = 4'h4;  37: row = 4'h4;  38: row = 4'h8;  39: row = 4'h8;
            40: row = 4'h0;  41: row = 4'h7;  42: row = 4'h0;  43: row = 4'hE;
            44: row = 4'hB;  45: row = 4'h0;  46: row = 4'hD;  47: row = 4'h0;
            48: row = 4'h1;  49: row = 4'h0;  50: row = 4'h2;  51: row = 4'h0;
            52: row = 4'h4;  53: row = 4'h0;  54: row = 4'h8;  55: row = 4'h0;
            56: row = 4'hF;  57: row = 4'h0;  58: row = 4'h5;  59: row = 4'hA;
            60: row = 4'h3;  61: row = 4'hC;  62: row = 4'h6;  63: row = 4'h9;
            default: row = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ddr_arrow_sequencer.sv
// Arrow sequencer: scrolls the song pattern down a ROWS-deep, 4-lane field on
// the selected beat tick, judges presses against the bottom (hit) row and
// keeps saturating hit/miss totals for the score display.
module ddr_arrow_sequencer
    import ddr_arrow_sequencer_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int SONG_LEN = 64,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          state,
    input  logic                tick_1hz,
    input  logic                tick_2hz,
    input  logic                tick_4hz,
    input  logic [1:0]          speed_sel,
    input  logic [3:0]          btn_press,
    output logic [4*ROWS-1:0]   field,
    output logic                hit_pulse,
    output logic                miss_pulse,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count,
    output logic                song_done
);

    localparam int IDX_W   = $clog2(SONG_LEN);
    localparam int DRAIN_W = $clog2(ROWS + 1);

    seqState_t              seqState;
    seqState_t              seqNext;
    logic [1:0]             stepSel;
    logic [IDX_W-1:0]       idx;
    logic [DRAIN_W-1:0]     drainCnt;
    logic [ROWS-1:0][3:0]   rows;
    logic [3:0]             romRow;

    logic                   gameOn;
    logic                   inPlay;
    logic                   tickSel;
    logic                   step;
    logic [3:0]             hitRow;
    logic [3:0]             pressHit;
    logic [3:0]             pressWrong;
    logic [3:0]             leftover;
    logic [3:0]             scrollMiss;
    logic [3:0]             hitInc;
    logic [3:0]             missInc;
    logic [3:0]             newRow;
    logic                   lastRow;
    logic                   drainLast;

    // Add a per-cycle increment to a total, pinning it at all-ones
    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] cnt,
                                                input logic [3:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    ddr_pattern_rom #(
        .SONG_LEN (SONG_LEN),
        .IDX_W    (IDX_W)
    ) u_rom (
        .idx (idx),
        .row (romRow)
    );

    // Step source selection and press judging against the pre-shift hit row
    always_comb begin
        gameOn     = (state == STATE_GAME);
        inPlay     = gameOn && ((seqState == SEQ_RUN) || (seqState == SEQ_DRAIN));
        case (stepSel)
            2'd0:    tickSel = tick_1hz;
            2'd1:    tickSel = tick_2hz;
            default: tickSel = tick_4hz;
        endcase
        step       = inPlay && tickSel;
        hitRow     = rows[ROWS-1];
        pressHit   = btn_press & hitRow;
        pressWrong = btn_press & ~hitRow;
        leftover   = hitRow & ~pressHit;
        scrollMiss = step ? leftover : 4'b0000;
        hitInc     = {1'b0, popcount4(pressHit)};
        missInc    = {1'b0, popcount4(pressWrong)} + {1'b0, popcount4(scrollMiss)};
        newRow     = (seqState == SEQ_RUN) ? romRow : 4'b0000;
        lastRow    = (idx == IDX_W'(SONG_LEN - 1));
        drainLast  = (drainCnt == DRAIN_W'(ROWS - 1));
    end

    // Next-state logic: RUN until the last song row is fed, DRAIN until the field empties
    always_comb begin
        seqNext = seqState;
        if (state == STATE_RESET) begin
            seqNext = SEQ_IDLE;
        end else begin
            case (seqState)
                SEQ_IDLE:  if (gameOn)               seqNext = SEQ_RUN;
                SEQ_RUN:   if (step && lastRow)      seqNext = SEQ_DRAIN;
                SEQ_DRAIN: if (step && drainLast)    seqNext = SEQ_DONE;
                SEQ_DONE:                            seqNext = SEQ_DONE;
                default:                             seqNext = SEQ_IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seqState <= SEQ_IDLE;
        else        seqState <= seqNext;
    end

    // Field shift register, pattern index, judge pulses and saturating totals
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stepSel    <= 2'd0;
            idx        <= '0;
            drainCnt   <= '0;
            rows       <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == STATE_RESET) begin
            stepSel    <= 2'd0;
            idx        <= '0;
            drainCnt   <= '0;
            rows       <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            if ((seqState == SEQ_IDLE) && gameOn) begin
                stepSel <= speed_sel;
            end
            if (inPlay) begin
                hit_pulse  <= |pressHit;
                miss_pulse <= (|pressWrong) || (|scrollMiss);
                hit_count  <= satAdd(hit_count, hitInc);
                miss_count <= satAdd(miss_count, missInc);
                if (step) begin
                    // Hit bits are dropped before the shift; only leftovers scroll out
                    rows <= {rows[ROWS-2:0], newRow};
                    if ((seqState == SEQ_RUN) && !lastRow) idx <= idx + 1'b1;
                    if (seqState == SEQ_DRAIN)            drainCnt <= drainCnt + 1'b1;
                end else begin
                    rows[ROWS-1] <= leftover;
                end
            end
        end
    end

    assign field     = rows;
    assign song_done = (seqState == SEQ_DONE);

endmodule

// File: tb/tb_ddr_arrow_sequencer.sv
// Self-checking bench for ddr_arrow_sequencer: a behavioural game model
// predicts every cycle's outputs into a queue; a monitor pops and compares.
module tb_ddr_arrow_sequencer;
    import ddr_arrow_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  state;
    logic        tick_1hz, tick_2hz, tick_4hz;
    logic [1:0]  speed_sel;
    logic [3:0]  btn_press;
    logic [31:0] field;
    logic        hit_pulse, miss_pulse;
    logic [7:0]  hit_count, miss_count;
    logic        song_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ddr_arrow_sequencer #(.ROWS(8), .SONG_LEN(64), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .tick_1hz   (tick_1hz),
        .tick_2hz   (tick_2hz),
        .tick_4hz   (tick_4hz),
        .speed_sel  (speed_sel),
        .btn_press  (btn_press),
        .field      (field),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .song_done  (song_done)
    );

    // Song as the player sees it, in pattern order
    logic [3:0] song [64] = '{
        4'h1, 4'h2, 4'h4, 4'h8,  4'h3, 4'h0, 4'h5, 4'hA,
        4'h0, 4'hC, 4'h1, 4'h0,  4'h9, 4'h6, 4'h0, 4'hF,
        4'h2, 4'h0, 4'h4, 4'h0,  4'h8, 4'h1, 4'h0, 4'h3,
        4'h5, 4'h0, 4'h6, 4'h0,  4'hA, 4'h0, 4'hC, 4'h0,
        4'h1, 4'h1, 4'h2, 4'h2,  4'h4, 4'h4, 4'h8, 4'h8,
        4'h0, 4'h7, 4'h0, 4'hE,  4'hB, 4'h0, 4'hD, 4'h0,
        4'h1, 4'h0, 4'h2, 4'h0,  4'h4, 4'h0, 4'h8, 4'h0,
        4'hF, 4'h0, 4'h5, 4'hA,  4'h3, 4'hC, 4'h6, 4'h9
    };

    typedef struct {
        logic [31:0] f;
        logic        hp;
        logic        mp;
        logic [7:0]  hc;
        logic [7:0]  mc;
        logic        dn;
    } exp_t;

    exp_t expQ[$];

    // Game model: phase 0 waiting, 1 feeding song, 2 emptying field, 3 finished
    logic [3:0] mFld [8];
    int         mPhase, mPos, mDrained, mSpeed, mHc, mMc;
    logic       mHp, mMp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        for (int r = 0; r < 8; r++) mFld[r] = 4'h0;
        mPhase = 0; mPos = 0; mDrained = 0; mSpeed = 0;
        mHc = 0; mMc = 0; mHp = 1'b0; mMp = 1'b0;
    endtask

    task automatic modelStep(input logic [1:0] st, input logic t1, input logic t2,
                             input logic t4, input logic [1:0] spd, input logic [3:0] btn);
        logic [3:0] good, bad;
        int hits, misses;
        logic tick;
        mHp = 1'b0;
        mMp = 1'b0;
        if (!rst_n || st == STATE_RESET) begin
            modelReset();
            return;
        end
        if (mPhase == 0) begin
            if (st == STATE_GAME) begin
                mPhase = 1;
                mSpeed = int'(spd);
            end
        end else if (mPhase != 3 && st == STATE_GAME) begin
            tick   = (mSpeed == 0) ? t1 : (mSpeed == 1) ? t2 : t4;
            good   = btn & mFld[7];
            bad    = btn & ~mFld[7];
            hits   = $countones(good);
            misses = $countones(bad);
            mFld[7] = mFld[7] & ~good;
            if (tick) begin
                misses += $countones(mFld[7]);
                for (int r = 7; r > 0; r--) mFld[r] = mFld[r-1];
                if (mPhase == 1) begin
                    mFld[0] = song[mPos];
                    mPos++;
                    if (mPos == 64) mPhase = 2;
                end else begin
                    mFld[0] = 4'h0;
                    mDrained++;
                    if (mDrained == 8) mPhase = 3;
                end
            end
            mHp = (hits > 0);
            mMp = (misses > 0);
            mHc = (mHc + hits > 255) ? 255 : mHc + hits;
            mMc = (mMc + misses > 255) ? 255 : mMc + misses;
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the predicted outputs
    task automatic cyc(input logic [1:0] st, input logic t1, input logic t2,
                       input logic t4, input logic [1:0] spd, input logic [3:0] btn);
        exp_t e;
        @(negedge clk);
        state = st; tick_1hz = t1; tick_2hz = t2; tick_4hz = t4;
        speed_sel = spd; btn_press = btn;
        modelStep(st, t1, t2, t4, spd, btn);
        for (int r = 0; r < 8; r++) e.f[4*r +: 4] = mFld[r];
        e.hp = mHp; e.mp = mMp;
        e.hc = 8'(mHc); e.mc = 8'(mMc);
        e.dn = (mPhase == 3);
        expQ.push_back(e);
    endtask

    task automatic runRandom(input int maxCyc);
        int n;
        logic [1:0] st;
        n = 0;
        while (mPhase != 3 && n < maxCyc) begin
            st = ($urandom_range(0, 19) == 0) ? 2'(2 + $urandom_range(0, 1)) : STATE_GAME;
            cyc(st, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
            n++;
        end
        @(posedge clk); #2;
        chk("song_done_level", 32'(song_done), 32'd1);
        chk("field_empty_done", field, 32'd0);
    endtask

    // Monitor: compare DUT outputs with the oldest prediction after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("field",      field,              e.f);
                chk("hit_pulse",  32'(hit_pulse),     32'(e.hp));
                chk("miss_pulse", 32'(miss_pulse),    32'(e.mp));
                chk("hit_count",  32'(hit_count),     32'(e.hc));
                chk("miss_count", 32'(miss_count),    32'(e.mc));
                chk("song_done",  32'(song_done),     32'(e.dn));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        state = STATE_RESET;
        tick_1hz = 1'b0; tick_2hz = 1'b0; tick_4hz = 1'b0;
        speed_sel = 2'd0; btn_press = 4'h0;
        modelReset();
        repeat (3) cyc(STATE_RESET, 1'b1, 1'b1, 1'b1, 2'd0, 4'hF);
        @(posedge clk); #3;
        rst_n = 1'b1;
        cyc(STATE_RESET, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);

        // Game 1: 2Hz beat; the other ticks must not move the field
        cyc(STATE_GAME, 1'b0, 1'b0, 1'b0, 2'd1, 4'h0);
        for (int i = 0; i < 8; i++) begin
            cyc(STATE_GAME, 1'b1, 1'b0, 1'b0, 2'd3, 4'h0);
            cyc(STATE_GAME, 1'b0, 1'b0, 1'b1, 2'd0, 4'h0);
            cyc(STATE_GAME, 1'b0, 1'b1, 1'b0, 2'd2, 4'h0);
        end
        @(posedge clk); #2;
        chk("row7_after_8_steps", 32'(field[31:28]), 32'h1);
        cyc(STATE_GAME, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001);
        @(posedge clk); #2;
        chk("press_hit_pulse", 32'(hit_pulse), 32'd1);
        chk("press_hit_count", 32'(hit_count), 32'd1);
        chk("hit_row_cleared", 32'(field[31:28]), 32'h0);
        repeat (4) cyc(STATE_GAME, 1'b0, 1'b1, 1'b0, 2'd0, 4'h0);
        cyc(STATE_GAME, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0110);
        @(posedge clk); #2;
        chk("step_press_hit_count",  32'(hit_count),  32'd2);
        chk("step_press_miss_count", 32'(miss_count), 32'd5);
        chk("step_press_both_pulse", 32'({hit_pulse, miss_pulse}), 32'b11);
        runRandom(4000);
        repeat (20) cyc(STATE_GAME, 1'b1, 1'b1, 1'b1, 2'($urandom_range(0, 3)),
                        4'($urandom_range(0, 15)));

        // Game 2: miss total saturation, then asynchronous reset mid-run
        repeat (2) cyc(STATE_RESET, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        cyc(STATE_GAME, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);
        repeat (70) cyc(STATE_GAME, 1'b0, 1'b1, 1'b1, 2'd1, 4'hF);
        @(posedge clk); #2;
        chk("miss_count_saturated", 32'(miss_count), 32'd255);
        chk("miss_pulse_at_sat",    32'(miss_pulse), 32'd1);
        repeat (3) cyc(STATE_GAME, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        modelReset();
        #1;
        chk("async_rst_field", field, 32'd0);
        chk("async_rst_counts", 32'({hit_count, miss_count}), 32'd0);
        chk("async_rst_flags", 32'({hit_pulse, miss_pulse, song_done}), 32'd0);
        repeat (2) cyc(STATE_GAME, 1'b1, 1'b1, 1'b1, 2'd1, 4'hF);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Game 3: random speed and play from IDLE after reset release
        runRandom(4000);

        @(posedge clk); #2;
        chk("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
